clock: RTL and testbench
========================

Name: clock

Overview:
- 12-hour time-of-day clock with seconds, minutes, hours and an AM/PM flag.
- Advances one second per prescaled tick.
- Three user push-button inputs set minutes, set hours and toggle AM/PM.
- Leaf block feeding a display/BCD-conversion stage. Buttons arrive already debounced and synchronised to clk.

Parameters:
- TICKS_PER_SEC, 1, clk cycles per second; must be >= 1. A value of 1 advances one second every cycle (simulation). Board builds use the real clk frequency.
- CNT_W, $clog2(TICKS_PER_SEC)+1, prescaler counter width.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous active-high reset
- set_min  input  1  button: each press adds one minute
- set_hr  input  1  button: each press adds one hour
- set_AMPM  input  1  button: each press toggles AM/PM
- sec  output  6  seconds 0..59
- min  output  6  minutes 0..59
- hr  output  5  hours 1..12
- AMPM  output  1  0=AM, 1=PM

Behaviour:
- Reset: one clock with rst=1 forces the following. No other operation occurs while rst=1.
  - sec=0, min=0, hr=12, AMPM=0 (12:00:00 AM).
  - Prescaler=0.
  - Button history registers=0.
- All outputs are registered directly (no combinational paths from inputs).
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 and wraps.
  - tick=1 in the cycle where count==TICKS_PER_SEC-1.
  - With TICKS_PER_SEC=1, tick=1 every cycle. The first clock edge after rst falls gives sec=1.
- On tick, time advances as follows:
  - sec 0..58 -> sec+1.
  - sec 59 -> sec=0, carry to min.
  - min 59 with carry -> min=0, carry to hr.
  - hr 12 with carry -> hr=1.
  - hr 1..10 with carry -> hr+1.
  - hr 11 with carry -> hr=12 and AMPM toggles. So 11:59:59 AM -> 12:00:00 PM, and 11:59:59 PM -> 12:00:00 AM.
- Button press detection:
  - A press is a rising edge: input=1 while its registered previous value=0.
  - The field updates at that same clk edge, so it is visible the cycle after the input first goes high.
  - Holding a button high counts as exactly one press.
  - A button high at the first edge after reset counts as a press.
- set_min press: min = (min==59) ? 0 : min+1. No carry into hr; sec unchanged.
- set_hr press: hr = (hr==12) ? 1 : hr+1. AMPM is not changed.
- set_AMPM press: AMPM toggles.
- Simultaneous presses: all pressed fields update independently in the same cycle.
- Press coinciding with tick:
  - The tick's time advance is dropped for that cycle. Only the button updates apply.
  - The prescaler keeps counting, so the dropped second is lost.
- Out-of-range values (hr 0 or >12, min/sec >59) are unreachable; no recovery logic is required.

Decomposition:
- Package clock_pkg holds:
  - SEC_W=6, MIN_W=6, HR_W=5.
  - SEC_MAX=59, MIN_MAX=59, HR_FIRST=1, HR_LAST=12, HR_AMPM_FLIP=11.
  - AM=1'b0, PM=1'b1.
- Sub-module clock_btn_edge: one input and one registered history bit; outputs a one-cycle press pulse. Synchronous active-high rst clears the history. Instantiated three times.
- Prescaler, counters and AM/PM logic stay in the top level.

Test Plan:
- Reset: hold rst=1 for 3 cycles -> 12:00:00 AM (hr=12, min=0, sec=0, AMPM=0), unchanged while rst=1.
- Counting (TICKS_PER_SEC=1): release rst, run 60 cycles -> 12:01:00 AM.
  - Run 3600 cycles from reset -> 1:00:00 AM.
  - Run 43200 cycles -> 12:00:00 PM.
- Buttons, under reset-free counting with TICKS_PER_SEC=4 so there is no tick collision:
  - Two 1-cycle set_min pulses -> min +2.
  - set_min held 5 cycles -> min +1 only.
  - set_min at min=59 -> min=0, hr unchanged.
- set_hr at 12 -> 1 with AMPM unchanged; set_hr at 11 -> 12 with AMPM unchanged. set_AMPM pulse -> AMPM 0->1, second pulse -> 0.
- Rollovers, preset via buttons (sec unchanged after presets):
  - 11:59:59 AM + tick -> 12:00:00 PM.
  - 11:59:59 PM + tick -> 12:00:00 AM.
  - 12:59:59 + tick -> 1:00:00.
- Reset mid-run at an arbitrary time, and press coinciding with tick:
  - Assert rst one cycle at 3:27:41 PM -> 12:00:00 AM and prescaler 0; counting restarts next cycle.
  - set_min pulse coinciding with tick -> min+1, sec unchanged.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared widths, field limits and press bundle for the 12-hour time-of-day clock.
package clock_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam logic [SEC_W-1:0] SEC_MAX      = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX      = 6'd59;
    localparam logic [HR_W-1:0]  HR_FIRST     = 5'd1;
    localparam logic [HR_W-1:0]  HR_LAST      = 5'd12;
    localparam logic [HR_W-1:0]  HR_AMPM_FLIP = 5'd11;

    localparam logic AM = 1'b0;
    localparam logic PM = 1'b1;

    // One-cycle press pulses from the three buttons.
    typedef struct packed {
        logic min;
        logic hr;
        logic ampm;
    } press_t;

    // Increment with wrap for the minute field.
    function automatic logic [MIN_W-1:0] min_next(input logic [MIN_W-1:0] value);
        return (value == MIN_MAX) ? '0 : value + 6'd1;
    endfunction

    // Increment with wrap for the 12-hour field (12 is followed by 1).
    function automatic logic [HR_W-1:0] hr_next(input logic [HR_W-1:0] value);
        return (value == HR_LAST) ? HR_FIRST : value + 5'd1;
    endfunction

endpackage

// File: rtl/clock_btn_edge.sv
// Rising-edge detector for one debounced, synchronised push button.
module clock_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic prev;

    // Remember last cycle's button level; cleared so a button already high after reset counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= btn;
        end
    end

    // The press is consumed at the same edge by the time registers, so it stays combinational.
    assign press = btn & ~prev;

endmodule

// File: rtl/clock.sv
// 12-hour time-of-day clock with prescaled seconds and set buttons for minutes, hours and AM/PM.
module clock
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1,
    parameter int CNT_W         = $clog2(TICKS_PER_SEC) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_min,
    input  logic             set_hr,
    input  logic             set_AMPM,
    output logic [SEC_W-1:0] sec,
    output logic [MIN_W-1:0] min,
    output logic [HR_W-1:0]  hr,
    output logic             AMPM
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    press_t           press;
    logic             any_press;

    clock_btn_edge u_edge_min (
        .clk   (clk),
        .rst   (rst),
        .btn   (set_min),
        .press (press.min)
    );

    clock_btn_edge u_edge_hr (
        .clk   (clk),
        .rst   (rst),
        .btn   (set_hr),
        .press (press.hr)
    );

    clock_btn_edge u_edge_ampm (
        .clk   (clk),
        .rst   (rst),
        .btn   (set_AMPM),
        .press (press.ampm)
    );

    assign tick      = (cnt == CNT_LAST);
    assign any_press = press.min | press.hr | press.ampm;

    // Prescaler: free-running 0..TICKS_PER_SEC-1, unaffected by button presses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Time registers: button presses win over the tick, whose second is then simply lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec  <= '0;
            min  <= '0;
            hr   <= HR_LAST;
            AMPM <= AM;
        end else if (any_press) begin
            if (press.min) begin
                min <= min_next(min);
            end
            if (press.hr) begin
                hr <= hr_next(hr);
            end
            if (press.ampm) begin
                AMPM <= (AMPM == AM) ? PM : AM;
            end
        end else if (tick) begin
            if (sec != SEC_MAX) begin
                sec <= sec + 6'd1;
            end else begin
                sec <= '0;
                if (min != MIN_MAX) begin
                    min <= min + 6'd1;
                end else begin
                    min <= '0;
                    hr  <= hr_next(hr);
                    // Crossing 11:59:59 into 12:00:00 is where the half-day changes.
                    if (hr == HR_AMPM_FLIP) begin
                        AMPM <= (AMPM == AM) ? PM : AM;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clock.sv
// Bench for the 12-hour clock: two instances (1 and 4 ticks per second) share the inputs
// and are checked every cycle against a seconds-of-day model, plus hand-computed literals.
module tb_clock;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_min = 1'b0;
    logic set_hr = 1'b0;
    logic set_ampm = 1'b0;

    logic [5:0] sec1, min1, sec4, min4;
    logic [4:0] hr1, hr4;
    logic       ap1, ap4;

    always #5 clk = ~clk;

    clock #(.TICKS_PER_SEC(1)) dut1 (
        .clk(clk), .rst(rst), .set_min(set_min), .set_hr(set_hr), .set_AMPM(set_ampm),
        .sec(sec1), .min(min1), .hr(hr1), .AMPM(ap1)
    );

    clock #(.TICKS_PER_SEC(4)) dut4 (
        .clk(clk), .rst(rst), .set_min(set_min), .set_hr(set_hr), .set_AMPM(set_ampm),
        .sec(sec4), .min(min4), .hr(hr4), .AMPM(ap4)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: time as hour-of-day (0..23), minute, second
    int m_cnt [2];
    int m_h24 [2];
    int m_min [2];
    int m_sec [2];
    bit m_pmin [2];
    bit m_phr [2];
    bit m_pap [2];
    bit model_valid = 1'b0;
    bit mt, pmn, phr, pap;
    int tot;

    function automatic int tps(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int disp_hr(input int h24);
        return ((h24 % 12) == 0) ? 12 : (h24 % 12);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cnt[i] = 0; m_h24[i] = 0; m_min[i] = 0; m_sec[i] = 0;
                m_pmin[i] = 0; m_phr[i] = 0; m_pap[i] = 0;
            end else begin
                mt = (m_cnt[i] == tps(i) - 1);
                m_cnt[i] = mt ? 0 : m_cnt[i] + 1;
                pmn = set_min && !m_pmin[i];
                phr = set_hr && !m_phr[i];
                pap = set_ampm && !m_pap[i];
                if (pmn || phr || pap) begin
                    if (pmn) m_min[i] = (m_min[i] + 1) % 60;
                    if (phr) m_h24[i] = (m_h24[i] / 12) * 12 + ((m_h24[i] % 12) + 1) % 12;
                    if (pap) m_h24[i] = (m_h24[i] + 12) % 24;
                end else if (mt) begin
                    tot = (m_h24[i] * 3600 + m_min[i] * 60 + m_sec[i] + 1) % 86400;
                    m_h24[i] = tot / 3600;
                    m_min[i] = (tot / 60) % 60;
                    m_sec[i] = tot % 60;
                end
                m_pmin[i] = set_min;
                m_phr[i] = set_hr;
                m_pap[i] = set_ampm;
            end
        end
        if (rst) model_valid = 1'b1;
    end

    // Compare both instances against the model on every cycle once reset has been seen.
    always @(negedge clk) begin
        if (model_valid) begin
            check("model dut1 sec", sec1, m_sec[0]);
            check("model dut1 min", min1, m_min[0]);
            check("model dut1 hr", hr1, disp_hr(m_h24[0]));
            check("model dut1 AMPM", ap1, (m_h24[0] >= 12) ? 1 : 0);
            check("model dut4 sec", sec4, m_sec[1]);
            check("model dut4 min", min4, m_min[1]);
            check("model dut4 hr", hr4, disp_hr(m_h24[1]));
            check("model dut4 AMPM", ap4, (m_h24[1] >= 12) ? 1 : 0);
        end
    end

    // ---------------- stimulus helpers (all called at a negedge)
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit pm, input bit ph, input bit pa);
        set_min = pm; set_hr = ph; set_ampm = pa;
        @(negedge clk);
        set_min = 0; set_hr = 0; set_ampm = 0;
        @(negedge clk);
    endtask

    task automatic press_n(input int n, input bit pm, input bit ph, input bit pa);
        repeat (n) pulse(pm, ph, pa);
    endtask

    task automatic do_reset();
        rst = 1; step(1); rst = 0;
    endtask

    // Wait for dut4 to show :59, then for the next tick, bounded in both phases.
    task automatic roll_dut4(input string name);
        int k;
        k = 0;
        while (sec4 != 6'd59 && k < 400) begin @(negedge clk); k++; end
        check({name, " reach :59"}, sec4, 59);
        k = 0;
        while (sec4 == 6'd59 && k < 8) begin @(negedge clk); k++; end
        check({name, " tick wait"}, (k < 8) ? 1 : 0, 1);
    endtask

    task automatic expect4(input string name, input int h, input int m, input int s, input int a);
        check({name, " hr"}, hr4, h);
        check({name, " min"}, min4, m);
        check({name, " sec"}, sec4, s);
        check({name, " AMPM"}, ap4, a);
    endtask

    task automatic expect1(input string name, input int h, input int m, input int s, input int a);
        check({name, " hr"}, hr1, h);
        check({name, " min"}, min1, m);
        check({name, " sec"}, sec1, s);
        check({name, " AMPM"}, ap1, a);
    endtask

    initial begin
        int k;
        // Reset held three cycles
        repeat (3) begin
            @(negedge clk);
            expect1("reset dut1", 12, 0, 0, 0);
            expect4("reset dut4", 12, 0, 0, 0);
        end
        rst = 0;

        // Counting at one tick per cycle
        step(60);
        expect1("count 60", 12, 1, 0, 0);
        step(3600 - 60);
        expect1("count 3600", 1, 0, 0, 0);
        step(43200 - 3600);
        expect1("count 43200", 12, 0, 0, 1);

        // Buttons on the 4-tick instance
        do_reset();
        press_n(2, 1, 0, 0);
        check("two set_min pulses", min4, 2);
        set_min = 1; step(5); set_min = 0; step(1);
        check("set_min held", min4, 3);
        press_n(56, 1, 0, 0);
        check("set_min to 59", min4, 59);
        pulse(1, 0, 0);
        check("set_min wrap min", min4, 0);
        check("set_min wrap hr", hr4, 12);
        pulse(0, 1, 0);
        check("set_hr 12->1", hr4, 1);
        check("set_hr 12->1 AMPM", ap4, 0);
        press_n(10, 0, 1, 0);
        check("set_hr to 11", hr4, 11);
        pulse(0, 1, 0);
        check("set_hr 11->12", hr4, 12);
        check("set_hr 11->12 AMPM", ap4, 0);
        pulse(0, 0, 1);
        check("set_AMPM first", ap4, 1);
        pulse(0, 0, 1);
        check("set_AMPM second", ap4, 0);

        // Rollovers
        do_reset();
        press_n(11, 1, 1, 0);
        press_n(48, 1, 0, 0);
        check("preset 11:59 AM hr", hr4, 11);
        check("preset 11:59 AM min", min4, 59);
        roll_dut4("AM->PM");
        expect4("AM->PM", 12, 0, 0, 1);
        press_n(11, 1, 1, 0);
        press_n(48, 1, 0, 0);
        check("preset 11:59 PM hr", hr4, 11);
        check("preset 11:59 PM AMPM", ap4, 1);
        roll_dut4("PM->AM");
        expect4("PM->AM", 12, 0, 0, 0);
        press_n(59, 1, 0, 0);
        check("preset 12:59 min", min4, 59);
        roll_dut4("12->1");
        expect4("12->1", 1, 0, 0, 0);

        // Mid-run reset at 3:27:41 PM on the 1-tick instance
        do_reset();
        pulse(0, 1, 1);
        press_n(2, 0, 1, 0);
        press_n(27, 1, 0, 0);
        check("preset 3:27 PM hr", hr1, 3);
        check("preset 3:27 PM min", min1, 27);
        check("preset 3:27 PM AMPM", ap1, 1);
        k = 0;
        while (sec1 != 6'd41 && k < 60) begin @(negedge clk); k++; end
        check("preset 3:27:41 sec", sec1, 41);
        rst = 1; step(1);
        expect1("mid reset dut1", 12, 0, 0, 0);
        expect4("mid reset dut4", 12, 0, 0, 0);
        rst = 0; step(1);
        check("restart dut1 sec", sec1, 1);
        check("restart dut4 sec e1", sec4, 0);
        step(2);
        check("restart dut4 sec e3", sec4, 0);
        step(1);
        check("restart dut4 sec e4", sec4, 1);
        check("restart dut1 sec e4", sec1, 4);

        // Presses coinciding with ticks drop that second
        set_min = 1; step(1);
        check("collide dut1 min", min1, 1);
        check("collide dut1 sec", sec1, 4);
        check("no-collide dut4 min", min4, 1);
        set_min = 0; step(2);
        check("after collide dut1 sec", sec1, 6);
        set_min = 1; step(1);
        check("collide dut4 min", min4, 2);
        check("collide dut4 sec", sec4, 1);
        check("collide dut1 sec e8", sec1, 6);
        set_min = 0; step(4);
        check("after collide dut4 sec", sec4, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
